reg_shift_sequencer: RTL and testbench
======================================

// Module: reg_shift_sequencer
// PURPOSE
//  Multi-cycle controller for register-specified shifts (shift_operand[4]==1), the case the single-cycle Val2 path does not handle.
//  Sits in EXE beside the Val2 generator: accepts Rm, Rs[7:0] and shift type, and applies at most STEP bit positions per cycle.
//  Stalls the pipeline while working, then delivers Val2 for the ALU with a one-cycle done pulse.
// PARAMETERS
//  STEP   4   max bit positions shifted per SHIFT cycle; legal values 1,2,4,8,16
// PORTS
//  clk         in   1   pipeline clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   request; sampled only in IDLE
//  flush       in   1   abort current operation (branch taken)
//  rm_val      in   32  value to shift (`REGISTER_LEN)
//  rs_amt      in   8   shift amount, Rs[7:0]
//  shift_type  in   2   `LSL_SHIFT/`LSR_SHIFT/`ASR_SHIFT/`ROR_SHIFT
//  stall       out  1   freeze IF/ID/EXE; combinational
//  done        out  1   one-cycle pulse; val2_out valid this cycle
//  val2_out    out  32  shifted result; holds until the next done
// BEHAVIOUR
//  Reset: state=IDLE; stall=0, done=0, val2_out=0, internal remaining count=0.
//  States:
//   - IDLE  -> DONE  on start when trivial; -> SHIFT on start otherwise.
//   - SHIFT -> DONE  when remaining reaches 0.
//   - DONE  -> IDLE  unconditionally.
//  Trivial request, resolved in the start cycle and registered:
//   - amount 0, or ROR with rs_amt[4:0]==0: val2 = rm_val.
//   - LSL/LSR with rs_amt>=32: val2 = 0.
//   - ASR with rs_amt>=32: val2 = {32{rm_val[31]}}.
//  Non-trivial request:
//   - eff = rs_amt for LSL/LSR/ASR (1..31); eff = rs_amt[4:0] for ROR.
//   - Each SHIFT cycle shifts by min(remaining, STEP) and subtracts that from remaining.
//   - ASR fills with the sign bit; ROR rotates the 32-bit value.
//  Latency, start accepted at cycle T:
//   - trivial: done at T+1.
//   - non-trivial: k = ceil(eff/STEP) SHIFT cycles T+1..T+k; done at T+k+1.
//  stall = (IDLE & start & ~flush) | SHIFT. It is 0 in DONE, so the pipeline advances with val2_out.
//  Operands are latched at start; later changes on rm_val/rs_amt/shift_type are ignored until IDLE.
//  start outside IDLE is ignored; there is no queueing.
//  flush in IDLE or SHIFT -> IDLE next cycle; no done; val2_out keeps its previous value. flush in DONE has no effect (done already issued).
//  flush together with start in IDLE: flush wins, request dropped, stall=0.
//  rst mid-operation: back to IDLE next edge with reset values; rst overrides flush and start.
// CONFIGURATION
//  REG_SHIFT_CARRY_EN defined:
//   - adds ports carry_in (in, 1; CPSR C) and carry_out (out, 1; registered, valid with done, reset 0).
//   - carry_out = last bit shifted out, or bit 31 of the result for ROR.
//   - amount 0: carry_in.
//   - LSL==32: rm[0]; LSR==32: rm[31]; LSL/LSR>32: 0.
//   - ASR>=32: rm[31].
//   - ROR with amt[4:0]==0 and amt!=0: rm[31].
//  REG_SHIFT_CARRY_EN undefined: neither port exists; no carry logic.
// TESTING (STEP=4)
//  - LSL rm=0x00000001 amt=5 at T -> stall T..T+2; done at T+3; val2=0x00000020.
//  - ASR rm=0x80000000 amt=40 -> done at T+1; val2=0xFFFFFFFF; stall only at T; carry_out=1.
//  - ROR rm=0x000000F1 amt=36 (eff 4) -> one SHIFT cycle; done at T+2; val2=0x1000000F; carry_out=0.
//  - LSR rm=0x80000000 amt=31 -> 8 SHIFT cycles; done at T+9; val2=0x00000001; mid-op start ignored.
//  - flush at T+1 of LSL amt=20 -> IDLE at T+2; no done; val2 unchanged; next start accepted normally.
//  - rst at T+2 of a non-trivial shift -> IDLE; val2_out=0; done=0; stall=0 on the next cycle.

Source files
------------

// File: rtl/reg_shift_sequencer.sv
// reg_shift_sequencer
// Multi-cycle controller for register-specified shifts. It latches Rm, Rs[7:0]
// and the shift type on start, moves at most STEP bit positions per cycle, and
// stalls the pipeline until the result is ready. val2_out is then presented
// with a one-cycle done pulse.
// Out-of-range and zero amounts are resolved in the start cycle without any
// SHIFT cycles.
// Optional feature: define REG_SHIFT_CARRY_EN to add carry_in/carry_out, which
// produce the shifter carry (the last bit shifted out).
module reg_shift_sequencer #(
  parameter int unsigned STEP = 4  // 1, 2, 4, 8 or 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] rm_val,
  input  logic [7:0]  rs_amt,
  input  logic [1:0]  shift_type,
  output logic        stall,
  output logic        done,
  output logic [31:0] val2_out
`ifdef REG_SHIFT_CARRY_EN
  ,
  input  logic        carry_in,
  output logic        carry_out
`endif
);

  localparam logic [1:0] LSL_SHIFT = 2'd0;
  localparam logic [1:0] LSR_SHIFT = 2'd1;
  localparam logic [1:0] ASR_SHIFT = 2'd2;
  localparam logic [1:0] ROR_SHIFT = 2'd3;

  localparam logic [4:0] STEP_W = 5'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;   // partially shifted operand
  logic [4:0]  rem_q, rem_d;     // bit positions still to shift
  logic [1:0]  type_q, type_d;   // latched shift type
  logic [31:0] val2_q, val2_d;   // delivered result

  // Decode of the request presented in IDLE
  logic        trivial;
  logic [31:0] triv_val;

  // One SHIFT cycle of the datapath
  logic [4:0]  step_amt;
  logic [31:0] step_val;

`ifdef REG_SHIFT_CARRY_EN
  logic        carry_q, carry_d;
  logic        triv_c;
  logic        step_c;
  logic [4:0]  lsl_idx;
  logic [4:0]  lsr_idx;
`endif

  // Classify the incoming request and produce the trivial result directly
  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    trivial  = 1'b0;
    triv_val = rm_val;
`ifdef REG_SHIFT_CARRY_EN
    triv_c   = carry_in;
`endif
    if (rs_amt == 8'd0) begin
      trivial  = 1'b1;
      triv_val = rm_val;
    end else if (shift_type == ROR_SHIFT) begin
      if (rs_amt[4:0] == 5'd0) begin
        trivial  = 1'b1;
        triv_val = rm_val;
`ifdef REG_SHIFT_CARRY_EN
        triv_c   = rm_val[31];
`endif
      end
    end else if (|rs_amt[7:5]) begin
      trivial = 1'b1;
      if (shift_type == ASR_SHIFT) begin
        triv_val = {32{rm_val[31]}};
`ifdef REG_SHIFT_CARRY_EN
        triv_c   = rm_val[31];
`endif
      end else begin
        triv_val = 32'd0;
`ifdef REG_SHIFT_CARRY_EN
        if (rs_amt == 8'd32) begin
          triv_c = (shift_type == LSL_SHIFT) ? rm_val[0] : rm_val[31];
        end else begin
          triv_c = 1'b0;
        end
`endif
      end
    end
  end

  // Shift the working value by min(remaining, STEP) positions
  always_comb begin
    step_amt = (rem_q < STEP_W) ? rem_q : STEP_W;
    case (type_q)
      LSL_SHIFT: step_val = work_q << step_amt;
      LSR_SHIFT: step_val = work_q >> step_amt;
      ASR_SHIFT: step_val = $unsigned($signed(work_q) >>> step_amt);
      default:   step_val = (work_q >> step_amt) |
                            (work_q << (6'd32 - {1'b0, step_amt}));
    endcase
`ifdef REG_SHIFT_CARRY_EN
    lsl_idx = 5'(6'd32 - {1'b0, step_amt});
    lsr_idx = step_amt - 5'd1;
    case (type_q)
      LSL_SHIFT: step_c = work_q[lsl_idx];
      LSR_SHIFT,
      ASR_SHIFT: step_c = work_q[lsr_idx];
      default:   step_c = step_val[31];
    endcase
`endif
  end

  // Next-state logic and combinational stall/done outputs
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    type_d  = type_q;
    val2_d  = val2_q;
`ifdef REG_SHIFT_CARRY_EN
    carry_d = carry_q;
`endif
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          stall = 1'b1;
          if (trivial) begin
            val2_d  = triv_val;
`ifdef REG_SHIFT_CARRY_EN
            carry_d = triv_c;
`endif
            state_d = DONE;
          end else begin
            work_d  = rm_val;
            rem_d   = rs_amt[4:0];
            type_d  = shift_type;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        stall = 1'b1;
        if (flush) begin
          rem_d   = 5'd0;
          state_d = IDLE;
        end else begin
          work_d = step_val;
          rem_d  = rem_q - step_amt;
          if (rem_q == step_amt) begin
            val2_d  = step_val;
`ifdef REG_SHIFT_CARRY_EN
            carry_d = step_c;
`endif
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 32'd0;
      rem_q   <= 5'd0;
      type_q  <= LSL_SHIFT;
      val2_q  <= 32'd0;
`ifdef REG_SHIFT_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      val2_q  <= val2_d;
`ifdef REG_SHIFT_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign val2_out = val2_q;
`ifdef REG_SHIFT_CARRY_EN
  assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Testbench for reg_shift_sequencer (STEP=4). A cycle-timed model computes each
// result in one shot from the shift rules and predicts when done appears. The
// compare process checks stall/done/val2_out against it on every cycle.
// Directed vectors add literal expectations for results and latencies.
module tb_reg_shift_sequencer;

  localparam int unsigned STEP = 4;
  localparam logic [1:0] LSL = 2'd0;
  localparam logic [1:0] LSR = 2'd1;
  localparam logic [1:0] ASR = 2'd2;
  localparam logic [1:0] ROR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rm_val = 32'd0;
  logic [7:0]  rs_amt = 8'd0;
  logic [1:0]  shift_type = 2'd0;
  logic        carry_in = 1'b1;
  logic        stall;
  logic        done;
  logic [31:0] val2_out;
`ifdef REG_SHIFT_CARRY_EN
  logic        carry_out;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  reg_shift_sequencer #(.STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flush      (flush),
    .rm_val     (rm_val),
    .rs_amt     (rs_amt),
    .shift_type (shift_type),
    .stall      (stall),
    .done       (done),
    .val2_out   (val2_out)
`ifdef REG_SHIFT_CARRY_EN
    ,
    .carry_in   (carry_in),
    .carry_out  (carry_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Full-width result of a shift, {carry, value}, straight from the shift rules
  function automatic logic [32:0] model_shift(input logic [31:0] rm, input logic [7:0] n,
                                              input logic [1:0] t, input logic cin);
    logic [63:0] x;
    logic [31:0] v;
    logic        c;
    logic [4:0]  r;
    r = n[4:0];
    case (t)
      LSL: begin
        x = {32'd0, rm} << n;
        v = x[31:0];
        c = (n == 8'd0) ? cin : x[32];
      end
      LSR: begin
        x = {rm, 32'd0} >> n;
        v = x[63:32];
        c = (n == 8'd0) ? cin : x[31];
      end
      ASR: begin
        x = $unsigned($signed({rm, 32'd0}) >>> ((n > 8'd32) ? 8'd32 : n));
        v = x[63:32];
        c = (n == 8'd0) ? cin : x[31];
      end
      default: begin
        if (n == 8'd0) begin
          v = rm;
          c = cin;
        end else begin
          v = (rm >> r) | (rm << (6'd32 - {1'b0, r}));
          c = v[31];
        end
      end
    endcase
    return {c, v};
  endfunction

  // Cycles from the accepting cycle to the done cycle
  function automatic int model_lat(input logic [7:0] n, input logic [1:0] t);
    if (n == 8'd0 || (t == ROR && n[4:0] == 5'd0) || (t != ROR && n >= 8'd32))
      return 1;
    return (int'(n[4:0]) + int'(STEP) - 1) / int'(STEP) + 1;
  endfunction

  // Model: idle/busy with a predicted done cycle
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_val2 = 32'd0;
  logic        m_carry = 1'b0;
  logic [31:0] m_pend = 32'd0;
  logic        m_pend_c = 1'b0;

  always @(posedge clk) begin
    logic [32:0] res;
    if (rst) begin
      m_busy  = 1'b0;
      m_val2  = 32'd0;
      m_carry = 1'b0;
      chk_en  = 1'b1;
    end else if (m_busy) begin
      if (cyc == m_done_at) begin
        m_busy  = 1'b0;
        m_val2  = m_pend;
        m_carry = m_pend_c;
      end else if (flush) begin
        m_busy = 1'b0;
      end
    end else if (start && !flush) begin
      res       = model_shift(rm_val, rs_amt, shift_type, carry_in);
      m_pend    = res[31:0];
      m_pend_c  = res[32];
      m_busy    = 1'b1;
      m_done_at = cyc + model_lat(rs_amt, shift_type);
    end
    cyc++;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic e_done;
    logic e_stall;
    if (chk_en) begin
      e_done  = m_busy && (cyc == m_done_at);
      e_stall = (m_busy && (cyc < m_done_at)) || (!m_busy && start && !flush);
      check("cyc_stall", {31'd0, stall}, {31'd0, e_stall});
      check("cyc_done", {31'd0, done}, {31'd0, e_done});
      check("cyc_val2", val2_out, e_done ? m_pend : m_val2);
`ifdef REG_SHIFT_CARRY_EN
      check("cyc_carry", {31'd0, carry_out}, {31'd0, (e_done ? m_pend_c : m_carry)});
`endif
    end
  end

  typedef struct {
    logic [31:0] rm;
    logic [7:0]  amt;
    logic [1:0]  typ;
    logic [31:0] val;
    int          lat;
    logic        c;
    bit          poke;     // pulse start again while busy
    bit          fl_done;  // assert flush in the done cycle
  } vec_t;

  vec_t vecs[$];

  task automatic start_op(input logic [31:0] rm, input logic [7:0] amt,
                          input logic [1:0] typ, output int t0);
    @(posedge clk);
    #1;
    start      = 1'b1;
    rm_val     = rm;
    rs_amt     = amt;
    shift_type = typ;
    t0         = cyc;
    @(posedge clk);
    #1;
    start      = 1'b0;
    rm_val     = $urandom;
    rs_amt     = 8'($urandom);
    shift_type = 2'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t0;
    int lat;
    lat = -1;
    start_op(v.rm, v.amt, v.typ, t0);
    if (v.poke) begin
      start = 1'b1;
      rs_amt = 8'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    check($sformatf("vec%0d_lat", idx), 32'(lat), 32'(v.lat));
    check($sformatf("vec%0d_val2", idx), val2_out, v.val);
`ifdef REG_SHIFT_CARRY_EN
    check($sformatf("vec%0d_carry", idx), {31'd0, carry_out}, {31'd0, v.c});
`endif
    if (v.fl_done) begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_hold", idx), val2_out, v.val);
    end
  endtask

  initial begin
    int  t0;
    bit  saw;
    //               rm            amt    typ  val           lat c     poke fl_done
    vecs.push_back(vec_t'{32'h00000001, 8'd5,  LSL, 32'h00000020, 3, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h80000000, 8'd40, ASR, 32'hFFFFFFFF, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h000000F1, 8'd36, ROR, 32'h1000000F, 2, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h80000000, 8'd31, LSR, 32'h00000001, 9, 1'b0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{32'h12345678, 8'd8,  ROR, 32'h78123456, 3, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h80000018, 8'd4,  ASR, 32'hF8000001, 2, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'hFFFFFFFF, 8'd32, LSL, 32'h00000000, 1, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{32'hDEADBEEF, 8'd0,  LSR, 32'hDEADBEEF, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h87654321, 8'd32, ROR, 32'h87654321, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h40000000, 8'd33, ASR, 32'h00000000, 1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h00000003, 8'd31, LSL, 32'h80000000, 9, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h00000001, 8'd1,  ROR, 32'h80000000, 2, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'hF0000000, 8'd17, ASR, 32'hFFFFF800, 6, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h80000000, 8'd32, LSR, 32'h00000000, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{32'h80000000, 8'd33, LSL, 32'h00000000, 1, 1'b0, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_val2", val2_out, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Flush during SHIFT: no done, result held, next request works
    run_vec(vecs[0], 100);
    start_op(32'h00000001, 8'd20, LSL, t0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    check("flush_no_done", {31'd0, saw}, 32'd0);
    check("flush_val2_hold", val2_out, 32'h00000020);
    run_vec(vec_t'{32'h00000002, 8'd3, LSL, 32'h00000010, 2, 1'b0, 1'b0, 1'b0}, 101);

    // Flush together with start in IDLE drops the request
    @(posedge clk);
    #1;
    start  = 1'b1;
    flush  = 1'b1;
    rm_val = 32'h0000FFFF;
    rs_amt = 8'd4;
    shift_type = LSL;
    @(negedge clk);
    check("fs_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    check("fs_no_done", {31'd0, saw}, 32'd0);
    check("fs_val2_hold", val2_out, 32'h00000010);

    // Reset at T+2 of a non-trivial shift
    start_op(32'h00000001, 8'd20, LSL, t0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_val2", val2_out, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    run_vec(vecs[4], 102);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
